// File: rtl/fetch_ctrl.sv
// Fetch sequencer: reads imem at the current PC and hands each word downstream; it drives the PC register's select code.
// Latency: at least 3 cycles per instruction (REQ with same-cycle ack, OUT accepted, next REQ).
// Backpressure: the PC is held while the memory or consumer stalls; it advances only on a consumer accept.
module fetch_ctrl #(
    parameter int W      = 8,
    parameter int IW     = 32,
    parameter int TO_CYC = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  pc_cur_i,
    output logic [1:0]    sel_o,
    output logic [W-1:0]  pc_tgt_o,
    output logic          imem_req_o,
    output logic [W-1:0]  imem_addr_o,
    input  logic          imem_ack_i,
    input  logic [IW-1:0] imem_data_i,
    output logic [IW-1:0] instr_o,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    input  logic          jump_i,
    input  logic [W-1:0]  jump_tgt_i,
    input  logic          halt_i,
    output logic [1:0]    err_o,
    output logic [15:0]   instr_cnt_o
);

    localparam logic [1:0] SEL_RST  = 2'b00;
    localparam logic [1:0] SEL_HOLD = 2'b01;
    localparam logic [1:0] SEL_INC  = 2'b10;
    localparam logic [1:0] SEL_JMP  = 2'b11;

    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Counter value seen in the TO_CYC-th REQ cycle without an ack.
    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_OUT,
        S_HALT,
        S_ERR
    } state_t;

    state_t     state;
    logic [7:0] to_cnt;
    logic       accept;
    logic       jump_bad;

    assign accept      = (state == S_OUT) && instr_ready_i;
    assign jump_bad    = jump_i && (jump_tgt_i[1:0] != 2'b00);
    assign pc_tgt_o    = jump_tgt_i;
    assign imem_addr_o = pc_cur_i;

    // Select must react within the accept cycle so the PC moves on that same edge.
    always_comb begin
        sel_o = SEL_HOLD;
        if (rst) begin
            sel_o = SEL_RST;
        end else if (accept) begin
            if (!jump_i) begin
                sel_o = SEL_INC;
            end else if (!jump_bad) begin
                sel_o = SEL_JMP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            instr_o       <= '0;
            instr_valid_o <= 1'b0;
            imem_req_o    <= 1'b0;
            err_o         <= 2'b00;
            instr_cnt_o   <= 16'd0;
            to_cnt        <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!halt_i) begin
                        state      <= S_REQ;
                        imem_req_o <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem_ack_i) begin
                        instr_o       <= imem_data_i;
                        instr_valid_o <= 1'b1;
                        to_cnt        <= 8'd0;
                        imem_req_o    <= 1'b0;
                        state         <= S_OUT;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                        if (to_cnt == TO_LAST) begin
                            err_o      <= ERR_TIMEOUT;
                            imem_req_o <= 1'b0;
                            state      <= S_ERR;
                        end
                    end
                end
                S_OUT: begin
                    if (instr_ready_i) begin
                        instr_valid_o <= 1'b0;
                        instr_cnt_o   <= instr_cnt_o + 16'd1;
                        if (jump_bad) begin
                            err_o <= ERR_ALIGN;
                            state <= S_ERR;
                        end else if (halt_i) begin
                            state <= S_HALT;
                        end else begin
                            state      <= S_REQ;
                            imem_req_o <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (!halt_i) begin
                        state      <= S_REQ;
                        imem_req_o <= 1'b1;
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed stimulus queues drive memory and consumer; a monitor pops expected
// requests, accepts and error codes from scoreboard queues whenever the DUT presents them.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc_cur_i;
    logic [1:0]  sel_o;
    logic [7:0]  pc_tgt_o;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        jump_i;
    logic [7:0]  jump_tgt_i;
    logic        halt_i;
    logic [1:0]  err_o;
    logic [15:0] instr_cnt_o;

    fetch_ctrl #(.W(8), .IW(32), .TO_CYC(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_cur_i      (pc_cur_i),
        .sel_o         (sel_o),
        .pc_tgt_o      (pc_tgt_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .jump_i        (jump_i),
        .jump_tgt_i    (jump_tgt_i),
        .halt_i        (halt_i),
        .err_o         (err_o),
        .instr_cnt_o   (instr_cnt_o)
    );

    always #5 clk = ~clk;

    // PC register the sequencer steers.
    always @(posedge clk) begin
        case (sel_o)
            2'b00:   pc_cur_i <= 8'h00;
            2'b10:   pc_cur_i <= pc_cur_i + 8'h04;
            2'b11:   pc_cur_i <= pc_tgt_o;
            default: pc_cur_i <= pc_cur_i;
        endcase
    end

    typedef struct { logic [7:0] addr; int len; } req_t;
    typedef struct { logic [31:0] instr; logic [1:0] sel; logic [7:0] tgt; } acc_t;
    typedef struct { int stall; bit jump; logic [7:0] tgt; bit halt; int hold; } act_t;

    req_t       exp_req[$];
    acc_t       exp_acc[$];
    logic [1:0] exp_err[$];
    int         delays[$];
    act_t       acts[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, act, $time);
    endtask

    // Memory: per-request ack delay from the queue; stray acks with junk data whenever no request is up.
    initial begin : responder
        int n;
        int dly;
        n = 0;
        dly = 0;
        imem_ack_i  = 1'b0;
        imem_data_i = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && imem_req_o) begin
                if (n == 0) dly = (delays.size() > 0) ? delays.pop_front() : 0;
                n++;
                imem_ack_i  = (n > dly);
                imem_data_i = imem_ack_i ? (32'hC0DE_0000 | 32'(imem_addr_o)) : 32'hDEAD_BEEF;
            end else begin
                n = 0;
                imem_ack_i  = !rst;
                imem_data_i = 32'hBAD0_0000;
            end
        end
    end

    initial begin : consumer
        act_t a;
        instr_ready_i = 1'b0;
        jump_i        = 1'b0;
        jump_tgt_i    = 8'h00;
        halt_i        = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid_o) begin
                if (acts.size() > 0) a = acts.pop_front();
                else a = '{0, 1'b0, 8'h00, 1'b0, 0};
                instr_ready_i = 1'b0;
                repeat (a.stall) @(negedge clk);
                instr_ready_i = 1'b1;
                jump_i        = a.jump;
                jump_tgt_i    = a.tgt;
                halt_i        = a.halt;
                @(negedge clk);
                instr_ready_i = 1'b0;
                jump_i        = 1'b0;
                jump_tgt_i    = 8'h00;
                if (a.halt) begin
                    repeat (a.hold) @(negedge clk);
                    halt_i = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        int         rq_len;
        int         mcnt;
        bit         in_rst;
        logic [1:0] prev_err;
        rq_len   = 0;
        mcnt     = 0;
        in_rst   = 1'b1;
        prev_err = 2'b00;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                in_rst = 1'b1;
                rq_len = 0;
                mcnt   = 0;
                check("sel_in_reset", 32'(sel_o), 32'h0);
            end else begin
                if (in_rst) begin
                    check("rst_valid", 32'(instr_valid_o), 32'h0);
                    check("rst_req", 32'(imem_req_o), 32'h0);
                    check("rst_err", 32'(err_o), 32'h0);
                    check("rst_cnt", 32'(instr_cnt_o), 32'h0);
                    check("rst_instr", instr_o, 32'h0);
                    prev_err = err_o;
                    in_rst   = 1'b0;
                end
                if (imem_req_o) begin
                    rq_len++;
                    check("req_sel", 32'(sel_o), 32'h1);
                    if (exp_req.size() == 0) begin
                        note_fail("req_unexpected", 32'(imem_addr_o));
                    end else begin
                        check("req_addr", 32'(imem_addr_o), 32'(exp_req[0].addr));
                        if (imem_ack_i) begin
                            check("req_len", rq_len, exp_req[0].len);
                            void'(exp_req.pop_front());
                            rq_len = 0;
                        end
                    end
                end else if (rq_len > 0) begin
                    // Request withdrawn without an ack: only a timeout may do this.
                    if (exp_req.size() == 0) note_fail("req_drop_unexpected", rq_len);
                    else check("req_len_timeout", rq_len, exp_req.pop_front().len);
                    rq_len = 0;
                end
                if (instr_valid_o) begin
                    if (exp_acc.size() == 0) begin
                        note_fail("instr_unexpected", instr_o);
                    end else begin
                        check("instr", instr_o, exp_acc[0].instr);
                        if (instr_ready_i) begin
                            check("acc_sel", 32'(sel_o), 32'(exp_acc[0].sel));
                            if (exp_acc[0].sel == 2'b11) check("acc_tgt", 32'(pc_tgt_o), 32'(exp_acc[0].tgt));
                            check("acc_cnt", 32'(instr_cnt_o), mcnt);
                            mcnt++;
                            void'(exp_acc.pop_front());
                        end else begin
                            check("stall_sel", 32'(sel_o), 32'h1);
                        end
                    end
                end else if (!imem_req_o) begin
                    check("hold_sel", 32'(sel_o), 32'h1);
                end
                if (err_o !== prev_err) begin
                    if (exp_err.size() == 0) note_fail("err_unexpected", 32'(err_o));
                    else check("err_code", 32'(err_o), 32'(exp_err.pop_front()));
                    prev_err = err_o;
                end
            end
        end
    end

    task automatic wait_cnt(input logic [15:0] n, input int budget, input string name);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            #3;
            i++;
        end while (instr_cnt_o !== n && i < budget);
        check(name, 32'(instr_cnt_o), 32'(n));
    endtask

    task automatic wait_err(input logic [1:0] code, input int budget, input string name);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            #3;
            i++;
        end while (err_o === 2'b00 && i < budget);
        check(name, 32'(err_o), 32'(code));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        rst = 1'b1;
        // Sequential fetch, delayed ack, consumer stall, halt, jump, ack on the last allowed cycle, timeout.
        delays = '{0, 4, 0, 0, 14, 255};
        exp_req.push_back('{8'h00, 1});
        exp_req.push_back('{8'h04, 5});
        exp_req.push_back('{8'h08, 1});
        exp_req.push_back('{8'h0C, 1});
        exp_req.push_back('{8'h40, 15});
        exp_req.push_back('{8'h44, 15});
        acts.push_back('{0, 1'b0, 8'h00, 1'b0, 0});
        acts.push_back('{3, 1'b0, 8'h00, 1'b0, 0});
        acts.push_back('{0, 1'b0, 8'h00, 1'b1, 3});
        acts.push_back('{0, 1'b1, 8'h40, 1'b0, 0});
        acts.push_back('{0, 1'b0, 8'h00, 1'b0, 0});
        exp_acc.push_back('{32'hC0DE_0000, 2'b10, 8'h00});
        exp_acc.push_back('{32'hC0DE_0004, 2'b10, 8'h00});
        exp_acc.push_back('{32'hC0DE_0008, 2'b10, 8'h00});
        exp_acc.push_back('{32'hC0DE_000C, 2'b11, 8'h40});
        exp_acc.push_back('{32'hC0DE_0040, 2'b10, 8'h00});
        exp_err.push_back(2'b10);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        wait_cnt(16'd3, 200, "cnt_after_three");
        repeat (2) begin
            @(negedge clk);
            #3;
            check("halt_no_req", 32'(imem_req_o), 32'h0);
        end
        wait_err(2'b10, 300, "err_timeout");
        check("timeout_req_low", 32'(imem_req_o), 32'h0);
        repeat (5) @(negedge clk);
        #3;
        check("err_state_req", 32'(imem_req_o), 32'h0);
        check("err_state_valid", 32'(instr_valid_o), 32'h0);

        // Misaligned jump: counted accept, PC held, sticky error until reset.
        pulse_reset();
        delays.push_back(0);
        exp_req.push_back('{8'h00, 1});
        acts.push_back('{0, 1'b1, 8'h42, 1'b0, 0});
        exp_acc.push_back('{32'hC0DE_0000, 2'b01, 8'h00});
        exp_err.push_back(2'b01);
        rst = 1'b0;
        wait_err(2'b01, 100, "err_misaligned");
        repeat (5) @(negedge clk);
        #3;
        check("misalign_req", 32'(imem_req_o), 32'h0);
        check("misalign_valid", 32'(instr_valid_o), 32'h0);
        check("misalign_cnt", 32'(instr_cnt_o), 32'h1);
        check("misalign_err_sticky", 32'(err_o), 32'h1);

        // Recovery after reset: fetch restarts at PC 0, then halt parks the sequencer.
        pulse_reset();
        delays.push_back(0);
        exp_req.push_back('{8'h00, 1});
        acts.push_back('{0, 1'b0, 8'h00, 1'b1, 1000});
        exp_acc.push_back('{32'hC0DE_0000, 2'b10, 8'h00});
        rst = 1'b0;
        wait_cnt(16'd1, 100, "cnt_after_recovery");
        check("recovery_err", 32'(err_o), 32'h0);
        repeat (5) @(negedge clk);
        #3;
        check("parked_req", 32'(imem_req_o), 32'h0);

        check("left_req", exp_req.size(), 0);
        check("left_acc", exp_acc.size(), 0);
        check("left_err", exp_err.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer that drives the program counter register's select code and jump target, and consumes its current PC value. It issues instruction-memory reads at the current PC with a req/ack handshake and presents each fetched word downstream on a valid/ready handshake. It advances the PC by +4, or jumps, only when the consumer accepts an instruction. It also holds the PC during memory stalls, consumer stalls and halts, and flags misaligned jumps and memory timeouts.

Parameters:
W, 8, PC/address width; must match the PC register width
IW, 32, instruction word width
TO_CYC, 15, maximum REQ cycles without imem_ack_i before a timeout error (1..255)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous, active-high
pc_cur_i  in  W  current PC (PC register output)
sel_o  out  2  PC select code: 00 reset, 01 hold, 10 PC+4, 11 jump
pc_tgt_o  out  W  jump target to the PC register; meaningful only when sel_o=11
imem_req_o  out  1  instruction memory read request
imem_addr_o  out  W  read address; equals pc_cur_i while imem_req_o=1
imem_ack_i  in  1  memory ack; imem_data_i is valid in the same cycle
imem_data_i  in  IW  read data
instr_o  out  IW  fetched instruction (registered)
instr_valid_o  out  1  instr_o valid
instr_ready_i  in  1  consumer accepts instr_o
jump_i  in  1  jump request; sampled only in the accept cycle
jump_tgt_i  in  W  jump target; sampled with jump_i
halt_i  in  1  stop fetching after the current instruction
err_o  out  2  sticky error: 01 misaligned jump, 10 timeout, 00 none
instr_cnt_o  out  16  accepted-instruction count; wraps 0xFFFF->0

Behaviour:
- Synchronous active-high reset. While rst=1, sel_o=00 combinationally. After the reset edge: state IDLE, instr_o=0, instr_valid_o=0, imem_req_o=0, err_o=00, instr_cnt_o=0, internal timeout counter=0.
- Accept cycle ("accept") = state OUT and instr_ready_i=1.
- States and outputs:
  - IDLE: sel_o=01, no req. If halt_i=1, stay; else go to REQ next cycle.
  - REQ: imem_req_o=1, imem_addr_o=pc_cur_i, sel_o=01.
    - On imem_ack_i=1: instr_o<=imem_data_i, instr_valid_o<=1, clear timeout counter, go to OUT.
    - No ack: increment timeout counter. If no ack has arrived by the TO_CYC-th REQ cycle, set err_o=10 and go to ERR. An ack in that same cycle wins over the timeout.
  - OUT: instr_valid_o=1, instr_o stable, sel_o=01 until accept.
    - On accept with jump_i=0: sel_o=10.
    - On accept with jump_i=1 and jump_tgt_i[1:0]=00: sel_o=11, pc_tgt_o=jump_tgt_i.
    - On accept with jump_i=1 and jump_tgt_i[1:0]!=00: sel_o=01 (PC not modified), err_o=01, go to ERR.
    - Every accept: instr_cnt_o increments and instr_valid_o clears at that edge.
    - After a good accept: go to HALT if halt_i=1, else REQ. The PC updates on the same edge, so the next REQ cycle uses the new pc_cur_i.
  - HALT: sel_o=01, no req. When halt_i=0, go to REQ.
  - ERR: sel_o=01, no req, instr_valid_o=0. Exit only via rst. err_o holds its value.
- Latency: minimum 3 cycles per instruction (REQ with same-cycle ack, OUT with ready, next REQ).
- imem_ack_i outside REQ is ignored. jump_i and halt_i outside the accept cycle are ignored, except halt_i in IDLE/HALT.
- A single fetch is outstanding at most. imem_req_o stays high through REQ until ack; never two acks per request.
- Reset mid-fetch: the request drops after the reset edge and a pending ack is ignored. The first request after reset is at PC 0.
- pc_tgt_o = jump_tgt_i combinationally; value is don't-care when sel_o!=11.

Test Plan:
- Reset, memory acks in the same cycle, ready tied 1 -> addresses 0x00, 0x04, 0x08; sel_o pattern 01,10 per instruction; instr_cnt_o=3 after the third accept.
- Memory ack delayed 4 cycles at PC 0x04 -> imem_req_o held high 5 cycles, sel_o=01 throughout, addr stays 0x04, instr_o captured on the ack cycle.
- Accept with jump_i=1, jump_tgt_i=0x40 -> sel_o=11, pc_tgt_o=0x40 in the accept cycle; next request addr=0x40.
- Jump to 0x42 -> sel_o=01, err_o=01, ERR entered, no further requests until rst; after reset, requests resume at 0x00 with err_o=00.
- TO_CYC=15, no ack -> err_o=10 after the 15th REQ cycle, imem_req_o low next cycle. Repeat with ack on the 15th cycle -> no error.
- halt_i=1 during accept at PC 0x08 -> PC advances to 0x0C, HALT entered, no req. Consumer holds ready=0 for 3 cycles in OUT -> instr_o and sel_o=01 stable. halt_i=0 -> request at 0x0C.
